// File: rtl/main_mem_if.sv
// Bus interface for the main memory model.
// Carries the request, write data, read data and burst status between the
// processor-side master and the memory (slave). All vectors use [0:N]
// ordering so that bit 0 is the MSB, matching the big-endian datapath.
//   addr      master->slave  byte address (low two bits ignored)
//   data_in   master->slave  write data
//   acc_size  master->slave  00=1, 01=4, 10=8, 11=16 words
//   wren      master->slave  1=write, 0=read
//   enable    master->slave  0 = idle, aborts any burst
//   data_out  slave->master  registered read data
//   busy      slave->master  high while a multi-word burst is in progress
interface main_mem_if;
  logic [0:31] addr;
  logic [0:31] data_in;
  logic [0:31] data_out;
  logic [0:1]  acc_size;
  logic        wren;
  logic        busy;
  logic        enable;

  modport master (
    output addr, data_in, acc_size, wren, enable,
    input  data_out, busy
  );

  modport slave (
    input  addr, data_in, acc_size, wren, enable,
    output data_out, busy
  );
endinterface

// File: rtl/main_mem.sv
// main_mem: byte-addressed, big-endian, word-wide main memory model.
// Serves single-word and 4/8/16-word burst reads/writes, one word per clock,
// for the address window [BASE_ADDR, BASE_ADDR+MEM_BYTES).
// Ports:
//   clock  single clock, all state changes on posedge
//   reset  asynchronous, active-high; memory contents are not cleared
//   bus    main_mem_if.slave (addr, data_in, acc_size, wren, enable in;
//          data_out, busy out)
// Optional feature macro: MAIN_MEM_DUMP_EN adds a per-word written flag and a
// simulation-only dump() task listing every word written since reset.
//
// state  | meaning
// IDLE   | accepts a request every cycle while enable=1 (beat 0 of a burst)
// WBURST | writing beats 1..N-1 of a burst, data_in sampled each beat
// RBURST | reading beats 1..N-1 of a burst, data_out updated each beat
module main_mem #(
  parameter logic [31:0] BASE_ADDR = 32'h80020000,
  parameter int          MEM_BYTES = 1048576
) (
  input  logic      clock,
  input  logic      reset,
  main_mem_if.slave bus
);

  localparam int          WORDS       = MEM_BYTES / 4;
  localparam int          IW          = $clog2(WORDS);
  localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RBURST = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] beat_addr_q, beat_addr_d;
  // Beats still to perform after the current one; last beat when it reads 1.
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        busy_q, busy_d;
  logic [0:31] data_out_q, data_out_d;

  logic [0:31] mem [WORDS];

  logic          acc_en;
  logic          acc_wr;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_off;
  logic          acc_hit;
  logic [IW-1:0] acc_idx;
  logic [0:31]   rd_word;

  // Unsigned wrap of the subtraction puts addresses below the base far above
  // MEM_BYTES, so one compare covers both ends of the window.
  always_comb begin
    acc_off = (acc_addr & 32'hFFFF_FFFC) - BASE_ADDR;
    acc_hit = (acc_off < MEM_BYTES_W);
    acc_idx = acc_off[IW+1:2];
    rd_word = mem[acc_idx];
  end

  always_comb begin
    state_d     = state_q;
    beat_addr_d = beat_addr_q;
    beat_cnt_d  = beat_cnt_q;
    busy_d      = busy_q;
    data_out_d  = data_out_q;
    acc_en      = 1'b0;
    acc_wr      = 1'b0;
    acc_addr    = beat_addr_q;

    if (!bus.enable) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      beat_cnt_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          acc_en      = 1'b1;
          acc_wr      = bus.wren;
          acc_addr    = bus.addr;
          beat_addr_d = bus.addr + 32'd4;
          case (bus.acc_size)
            2'b01:   beat_cnt_d = 4'd3;
            2'b10:   beat_cnt_d = 4'd7;
            2'b11:   beat_cnt_d = 4'd15;
            default: beat_cnt_d = 4'd0;
          endcase
          if (bus.acc_size != 2'b00) begin
            busy_d  = 1'b1;
            state_d = bus.wren ? WBURST : RBURST;
          end
        end
        WBURST, RBURST: begin
          acc_en      = 1'b1;
          acc_wr      = (state_q == WBURST);
          beat_addr_d = beat_addr_q + 32'd4;
          beat_cnt_d  = beat_cnt_q - 4'd1;
          if (beat_cnt_q == 4'd1) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          beat_cnt_d = 4'd0;
        end
      endcase

      if (acc_en && !acc_wr) begin
        data_out_d = acc_hit ? rd_word : 32'h0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_addr_q <= 32'h0;
      beat_cnt_q  <= 4'd0;
      busy_q      <= 1'b0;
      data_out_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      beat_addr_q <= beat_addr_d;
      beat_cnt_q  <= beat_cnt_d;
      busy_q      <= busy_d;
      data_out_q  <= data_out_d;
    end
  end

  // The array survives reset, so it sits in its own reset-free process.
  always_ff @(posedge clock) begin
    if (acc_en && acc_wr && acc_hit) begin
      mem[acc_idx] <= bus.data_in;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.busy     = busy_q;

`ifdef MAIN_MEM_DUMP_EN
  logic valid_q [WORDS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (acc_en && acc_wr && acc_hit) begin
      valid_q[acc_idx] <= 1'b1;
    end
  end

  task automatic dump();
    logic [31:0] a;
    for (int i = 0; i < WORDS; i++) begin
      if (valid_q[i]) begin
        a = BASE_ADDR + (32'(i) << 2);
        $display("%h: %h", a, mem[i]);
      end
    end
  endtask
`else
  // No written-word tracking in this build.
`endif

endmodule

// File: tb/tb_main_mem.sv
// Directed testbench for main_mem: single, streamed and burst accesses,
// mid-burst reset, out-of-range addresses and enable=0 behaviour.
module tb_main_mem;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  main_mem_if bus ();

  main_mem dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC3A5_0000 ^ {a[7:0], a[15:8], a[23:16], a[31:24]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setreq(input logic [31:0] a, input logic [1:0] sz,
                        input logic w, input logic [31:0] d);
    bus.addr     = a;
    bus.acc_size = sz;
    bus.wren     = w;
    bus.data_in  = d;
  endtask

  // Beat i writes pat(base+4i); request fields are scrambled after beat 0.
  task automatic burst_wr(input logic [31:0] base, input logic [1:0] sz, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) setreq(base, sz, 1'b1, pat(base));
      else begin
        bus.addr     = ~base ^ 32'(i);
        bus.acc_size = 2'b00;
        bus.wren     = 1'b0;
        bus.data_in  = pat(base + 32'(4 * i));
      end
      tick();
      chk($sformatf("wr_busy n%0d b%0d", n, i), 32'(bus.busy), 32'(i < n - 1));
    end
    setreq(base, 2'b00, 1'b0, 32'h0);
  endtask

  task automatic burst_rd(input logic [31:0] base, input logic [1:0] sz, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) setreq(base, sz, 1'b0, 32'h0);
      else begin
        bus.addr     = base + 32'h40 + 32'(4 * i);
        bus.acc_size = 2'b00;
        bus.wren     = 1'b1;
        bus.data_in  = 32'hDEAD_BEEF;
      end
      tick();
      chk($sformatf("rd_data n%0d b%0d", n, i), bus.data_out, pat(base + 32'(4 * i)));
      chk($sformatf("rd_busy n%0d b%0d", n, i), 32'(bus.busy), 32'(i < n - 1));
    end
    setreq(base, 2'b00, 1'b0, 32'h0);
  endtask

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b0;
    setreq(32'h8002_0000, 2'b00, 1'b0, 32'h0);
    #12;
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_data", bus.data_out, 32'h0);
    tick();
    reset      = 1'b0;
    bus.enable = 1'b1;

    // T1
    setreq(32'h8002_0000, 2'b00, 1'b1, 32'h27bd_fff8);
    tick();
    chk("t1_wr_busy", 32'(bus.busy), 32'h0);
    setreq(32'h8002_0000, 2'b00, 1'b0, 32'h0);
    tick();
    chk("t1_rd_data", bus.data_out, 32'h27bd_fff8);
    chk("t1_rd_busy", 32'(bus.busy), 32'h0);

    // T2, T3
    burst_wr(32'h8002_0004, 2'b01, 4);
    burst_rd(32'h8002_0004, 2'b01, 4);
    burst_wr(32'h8002_0014, 2'b10, 8);
    burst_wr(32'h8002_0034, 2'b11, 16);
    burst_rd(32'h8002_0014, 2'b10, 8);
    burst_rd(32'h8002_0034, 2'b11, 16);
    setreq(32'h8002_0000, 2'b00, 1'b0, 32'h0);
    tick();
    chk("t3_word0_kept", bus.data_out, 32'h27bd_fff8);

    // T4
    for (int i = 0; i < 40; i++) begin
      setreq(32'h8002_0100 + 32'(4 * i), 2'b00, 1'b1, pat(32'h8002_0100 + 32'(4 * i)));
      tick();
    end
    chk("t4_wr_busy", 32'(bus.busy), 32'h0);
    for (int i = 0; i < 40; i++) begin
      setreq(32'h8002_0100 + 32'(4 * i), 2'b00, 1'b0, 32'h0);
      tick();
      chk($sformatf("t4_rd %0d", i), bus.data_out, pat(32'h8002_0100 + 32'(4 * i)));
    end

    // T5
    setreq(32'h8002_0034, 2'b11, 1'b0, 32'h0);
    tick();
    chk("t5_beat0", bus.data_out, pat(32'h8002_0034));
    bus.addr = 32'h0;
    tick();
    tick();
    tick();
    chk("t5_beat3", bus.data_out, pat(32'h8002_0040));
    chk("t5_busy_pre", 32'(bus.busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(bus.busy), 32'h0);
    chk("t5_rst_data", bus.data_out, 32'h0);
    tick();
    reset = 1'b0;
    setreq(32'h8002_0050, 2'b00, 1'b0, 32'h0);
    tick();
    chk("t5_retained", bus.data_out, pat(32'h8002_0050));
    chk("t5_single_busy", 32'(bus.busy), 32'h0);

    // T6
    setreq(32'h8011_FFFC, 2'b00, 1'b1, pat(32'h8011_FFFC));
    tick();
    setreq(32'h8011_FFFC, 2'b00, 1'b0, 32'h0);
    tick();
    chk("t6_last_word", bus.data_out, pat(32'h8011_FFFC));
    setreq(32'h7FFF_FFFC, 2'b00, 1'b0, 32'h0);
    tick();
    chk("t6_rd_below", bus.data_out, 32'h0);
    setreq(32'h8011_FFFC, 2'b00, 1'b0, 32'h0);
    tick();
    setreq(32'h8012_0000, 2'b00, 1'b0, 32'h0);
    tick();
    chk("t6_rd_above", bus.data_out, 32'h0);
    setreq(32'h7FFF_FFFC, 2'b00, 1'b1, 32'h1111_1111);
    tick();
    setreq(32'h8012_0000, 2'b00, 1'b1, 32'h2222_2222);
    tick();
    setreq(32'h7FFF_FFFC, 2'b00, 1'b0, 32'h0);
    tick();
    chk("t6_wr_below_rd", bus.data_out, 32'h0);
    setreq(32'h8011_FFFC, 2'b00, 1'b0, 32'h0);
    tick();
    chk("t6_last_intact", bus.data_out, pat(32'h8011_FFFC));
    setreq(32'h8002_0000, 2'b00, 1'b0, 32'h0);
    tick();
    chk("t6_first_intact", bus.data_out, 32'h27bd_fff8);

    bus.enable = 1'b0;
    setreq(32'h8002_0004, 2'b00, 1'b0, 32'h0);
    tick();
    tick();
    chk("t6_en0_hold", bus.data_out, 32'h27bd_fff8);
    chk("t6_en0_busy", 32'(bus.busy), 32'h0);
    setreq(32'h8002_0000, 2'b00, 1'b1, 32'h0);
    tick();
    bus.enable = 1'b1;
    setreq(32'h8002_0000, 2'b00, 1'b0, 32'h0);
    tick();
    chk("t6_en0_nowrite", bus.data_out, 32'h27bd_fff8);

    setreq(32'h8002_0014, 2'b10, 1'b0, 32'h0);
    tick();
    bus.addr = 32'h0;
    tick();
    chk("t6_abort_beat1", bus.data_out, pat(32'h8002_0018));
    bus.enable = 1'b0;
    tick();
    chk("t6_abort_busy", 32'(bus.busy), 32'h0);
    chk("t6_abort_hold", bus.data_out, pat(32'h8002_0018));
    bus.enable = 1'b1;
    setreq(32'h8002_0040, 2'b00, 1'b0, 32'h0);
    tick();
    chk("t6_after_abort", bus.data_out, pat(32'h8002_0040));
    chk("t6_after_busy", 32'(bus.busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
